// File: rtl/ms3_rr_arbiter.sv
// ms3_rr_arbiter: round-robin arbiter and sequencer for the 3:1, 4-bit
// address-selected multiplexer. It grants one of three requesters at a time,
// drives the multiplexer select code, and registers the selected word with a
// valid flag.
// Optional build macro: MS3_ARB_LOCK_EN. It adds a `lock` input that lets the
// current owner extend its burst beyond BURST.

// 3:1 multiplexer with a 2-bit select. The code 2'b11 selects nothing and
// produces zero.
module ms3_mux3 #(
  parameter int W = 4
) (
  input  logic [1:0]   adr_i,
  input  logic [W-1:0] x0_i,
  input  logic [W-1:0] x1_i,
  input  logic [W-1:0] x2_i,
  output logic [W-1:0] y_o
);
  // Decode the select code; the idle code yields zero.
  always_comb begin
    case (adr_i)
      2'b00:   y_o = x0_i;
      2'b10:   y_o = x1_i;
      2'b01:   y_o = x2_i;
      default: y_o = '0;
    endcase
  end
endmodule

module ms3_rr_arbiter #(
  parameter int W     = 4,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   req,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  output logic [2:0]   gnt,
  output logic [1:0]   adr,
  output logic [W-1:0] y,
  output logic         vld
`ifdef MS3_ARB_LOCK_EN
  ,
  input  logic         lock
`endif
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [3:0] BURST_C = 4'(BURST);
  localparam logic [1:0] ADR_IDLE = 2'b11;

  state_e       state_q, state_d;
  logic [1:0]   owner_q, owner_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [2:0]   gnt_q, gnt_d;
  logic [1:0]   adr_q, adr_d;
  logic [W-1:0] y_q;
  logic         vld_q;
  logic [W-1:0] mux_y;

  logic [2:0]   others;
  logic         at_limit;
  logic         hold_lock;
  logic [1:0]   win;

  // Successor index modulo 3.
  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // One-hot grant vector for an owner index.
  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  // Multiplexer select code for an owner index.
  function automatic logic [1:0] code(input logic [1:0] i);
    case (i)
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b01;
      default: return ADR_IDLE;
    endcase
  endfunction

  // First set bit of r scanning start, start+1, start+2 (mod 3).
  // The scan runs backwards so the highest-priority hit is assigned last.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] start);
    logic [1:0] res;
    int         s;
    res = start;
    for (int k = 2; k >= 0; k--) begin
      s = int'(start) + k;
      if (s >= 3) s = s - 3;
      if (r[s]) res = 2'(s);
    end
    return res;
  endfunction

  ms3_mux3 #(.W(W)) u_mux (
    .adr_i (adr_q),
    .x0_i  (x0),
    .x1_i  (x1),
    .x2_i  (x2),
    .y_o   (mux_y)
  );

  // Next-state arbitration: grant from IDLE, hold/release/hand over in BUSY.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    adr_d    = adr_q;
    win      = 2'd0;
    others   = req & ~onehot(owner_q);
    at_limit = (cnt_q >= BURST_C);
`ifdef MS3_ARB_LOCK_EN
    hold_lock = lock & req[owner_q];
`else
    hold_lock = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          win     = pick(req, ptr_q);
          owner_d = win;
          gnt_d   = onehot(win);
          adr_d   = code(win);
          cnt_d   = 4'd1;
          state_d = BUSY;
        end else begin
          gnt_d = 3'b000;
          adr_d = ADR_IDLE;
        end
      end
      BUSY: begin
        if (!req[owner_q] || (at_limit && (others != 3'b000) && !hold_lock)) begin
          ptr_d = inc3(owner_q);
          if (others != 3'b000) begin
            // Hand over back-to-back, scanning from the owner's successor.
            win     = pick(others, inc3(owner_q));
            owner_d = win;
            gnt_d   = onehot(win);
            adr_d   = code(win);
            cnt_d   = 4'd1;
          end else begin
            gnt_d   = 3'b000;
            adr_d   = ADR_IDLE;
            cnt_d   = 4'd0;
            state_d = IDLE;
          end
        end else begin
          // Keep the grant; the count saturates at BURST.
          cnt_d = at_limit ? BURST_C : cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
        adr_d   = ADR_IDLE;
      end
    endcase
  end

  // Control registers; reset aborts any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      gnt_q   <= 3'b000;
      adr_q   <= ADR_IDLE;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      adr_q   <= adr_d;
    end
  end

  // Output data path: register the word selected by the current adr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= mux_y;
      vld_q <= (gnt_q != 3'b000);
    end
  end

  assign gnt = gnt_q;
  assign adr = adr_q;
  assign y   = y_q;
  assign vld = vld_q;

endmodule

// File: tb/tb_ms3_rr_arbiter.sv
// Directed testbench for ms3_rr_arbiter (BURST=4). Compile with
// MS3_ARB_LOCK_EN defined to include the lock scenario.
module tb_ms3_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [3:0] x0, x1, x2;
  logic [2:0] gnt;
  logic [1:0] adr;
  logic [3:0] y;
  logic       vld;
`ifdef MS3_ARB_LOCK_EN
  logic       lock;
`endif

  int errors = 0;
  int checks = 0;

  // Observed outputs packed as {gnt, adr, vld, y}.
  logic [9:0] obs;
  assign obs = {gnt, adr, vld, y};

  ms3_rr_arbiter #(.W(4), .BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .x0    (x0),
    .x1    (x1),
    .x2    (x2),
    .gnt   (gnt),
    .adr   (adr),
    .y     (y),
    .vld   (vld)
`ifdef MS3_ARB_LOCK_EN
    ,
    .lock  (lock)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    rst_n = 1'b0;
    req   = 3'b000;
    x0 = 4'h6; x1 = 4'h5; x2 = 4'hA;
    #12;
    e = {3'b000, 2'b11, 1'b0, 4'h0};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_init: gnt/adr/vld/y got %b/%b/%b/%h want %b/%b/%b/%h", gnt, adr, vld, y, e[9:7], e[6:5], e[4], e[3:0]);
    end
    req   = 3'b010;
    rst_n = 1'b1;
    step();
    e = {3'b010, 2'b10, 1'b0, 4'h0};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_grant1: gnt/adr/vld/y got %b/%b/%b/%h want %b/%b/%b/%h", gnt, adr, vld, y, e[9:7], e[6:5], e[4], e[3:0]);
    end
    step();
    e = {3'b010, 2'b10, 1'b1, 4'h5};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_busy: gnt/adr/vld/y got %b/%b/%b/%h want %b/%b/%b/%h", gnt, adr, vld, y, e[9:7], e[6:5], e[4], e[3:0]);
    end
    // Asynchronous reset mid-cycle, no clock edge in between.
    #2 rst_n = 1'b0;
    #1;
    e = {3'b000, 2'b11, 1'b0, 4'h0};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_async: gnt/adr/vld/y got %b/%b/%b/%h want %b/%b/%b/%h", gnt, adr, vld, y, e[9:7], e[6:5], e[4], e[3:0]);
    end
    req   = 3'b001;
    rst_n = 1'b1;
    step();
    e = {3'b001, 2'b00, 1'b0, 4'h0};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_regrant: gnt/adr/vld/y got %b/%b/%b/%h want %b/%b/%b/%h", gnt, adr, vld, y, e[9:7], e[6:5], e[4], e[3:0]);
    end
    req = 3'b000;
    step();
    step();
    e = {3'b000, 2'b11, 1'b0, 4'h0};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_idle: gnt/adr/vld/y got %b/%b/%b/%h want %b/%b/%b/%h", gnt, adr, vld, y, e[9:7], e[6:5], e[4], e[3:0]);
    end
  endtask

  // Sole requester 2 keeps the grant well past BURST.
  task automatic test_single();
    logic [9:0] e;
    for (int i = 1; i <= 12; i++) begin
      req = (i <= 10) ? 3'b100 : 3'b000;
      step();
      if (i == 1)       e = {3'b100, 2'b01, 1'b0, 4'h0};
      else if (i <= 10) e = {3'b100, 2'b01, 1'b1, 4'hA};
      else if (i == 11) e = {3'b000, 2'b11, 1'b1, 4'hA};
      else              e = {3'b000, 2'b11, 1'b0, 4'h0};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single step %0d: gnt/adr/vld/y got %b/%b/%b/%h want %b/%b/%b/%h", i, gnt, adr, vld, y, e[9:7], e[6:5], e[4], e[3:0]);
      end
    end
  endtask

  // All three request: owners 0,1,2 each for exactly 4 cycles, back-to-back.
  task automatic test_round_robin();
    logic [9:0] e;
    logic [1:0] code_tab [0:2];
    int         o, po;
    code_tab[0] = 2'b00; code_tab[1] = 2'b10; code_tab[2] = 2'b01;
    x0 = 4'h1; x1 = 4'h2; x2 = 4'h3;
    req = 3'b111;
    for (int i = 1; i <= 13; i++) begin
      step();
      o  = ((i - 1) / 4) % 3;
      po = ((i - 2) / 4) % 3;
      e  = {3'(3'b001 << o), code_tab[o], (i > 1), (i > 1) ? 4'(po + 1) : 4'h0};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL round_robin step %0d: gnt/adr/vld/y got %b/%b/%b/%h want %b/%b/%b/%h", i, gnt, adr, vld, y, e[9:7], e[6:5], e[4], e[3:0]);
      end
    end
    // Owner 0 (cycle 1 of its turn) drops out with the rest.
    req = 3'b000;
    step();
    step();
    e = {3'b000, 2'b11, 1'b0, 4'h0};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL round_robin_idle: gnt/adr/vld/y got %b/%b/%b/%h want %b/%b/%b/%h", gnt, adr, vld, y, e[9:7], e[6:5], e[4], e[3:0]);
    end
    // Owner 0 released, so the pointer now sits at 1; park it back at 0
    // by granting and releasing requester 2.
    req = 3'b100;
    step();
    req = 3'b000;
    step();
    step();
  endtask

  // Owner 1 drops after 2 cycles with req=101: next owner is 2, no gap.
  task automatic test_early_release();
    logic [9:0] e;
    logic [2:0] req_tab [1:6];
    logic [9:0] exp_tab [1:6];
    req_tab = '{3'b010, 3'b010, 3'b101, 3'b101, 3'b000, 3'b000};
    exp_tab = '{{3'b010, 2'b10, 1'b0, 4'h0},
                {3'b010, 2'b10, 1'b1, 4'h2},
                {3'b100, 2'b01, 1'b1, 4'h2},
                {3'b100, 2'b01, 1'b1, 4'h3},
                {3'b000, 2'b11, 1'b1, 4'h3},
                {3'b000, 2'b11, 1'b0, 4'h0}};
    for (int i = 1; i <= 6; i++) begin
      req = req_tab[i];
      step();
      e = exp_tab[i];
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL early_release step %0d: gnt/adr/vld/y got %b/%b/%b/%h want %b/%b/%b/%h", i, gnt, adr, vld, y, e[9:7], e[6:5], e[4], e[3:0]);
      end
    end
  endtask

  // Sole owner 0 drops its request: idle next edge, y/vld clear one edge later.
  task automatic test_idle_return();
    logic [9:0] e;
    logic [2:0] req_tab [1:4];
    logic [9:0] exp_tab [1:4];
    req_tab = '{3'b001, 3'b001, 3'b000, 3'b000};
    exp_tab = '{{3'b001, 2'b00, 1'b0, 4'h0},
                {3'b001, 2'b00, 1'b1, 4'h1},
                {3'b000, 2'b11, 1'b1, 4'h1},
                {3'b000, 2'b11, 1'b0, 4'h0}};
    for (int i = 1; i <= 4; i++) begin
      req = req_tab[i];
      step();
      e = exp_tab[i];
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL idle_return step %0d: gnt/adr/vld/y got %b/%b/%b/%h want %b/%b/%b/%h", i, gnt, adr, vld, y, e[9:7], e[6:5], e[4], e[3:0]);
      end
    end
  endtask

  // Mid-burst arrival waits for BURST; then req drop coinciding with BURST.
  task automatic test_burst_wait();
    logic [9:0] e;
    logic [2:0] req_tab [1:12];
    logic [9:0] exp_tab [1:12];
    req_tab = '{3'b100, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101,
                3'b101, 3'b101, 3'b100, 3'b100, 3'b000, 3'b000};
    exp_tab = '{{3'b100, 2'b01, 1'b0, 4'h0},
                {3'b100, 2'b01, 1'b1, 4'h3},
                {3'b100, 2'b01, 1'b1, 4'h3},
                {3'b100, 2'b01, 1'b1, 4'h3},
                {3'b001, 2'b00, 1'b1, 4'h3},
                {3'b001, 2'b00, 1'b1, 4'h1},
                {3'b001, 2'b00, 1'b1, 4'h1},
                {3'b001, 2'b00, 1'b1, 4'h1},
                {3'b100, 2'b01, 1'b1, 4'h1},
                {3'b100, 2'b01, 1'b1, 4'h3},
                {3'b000, 2'b11, 1'b1, 4'h3},
                {3'b000, 2'b11, 1'b0, 4'h0}};
    for (int i = 1; i <= 12; i++) begin
      req = req_tab[i];
      step();
      e = exp_tab[i];
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL burst_wait step %0d: gnt/adr/vld/y got %b/%b/%b/%h want %b/%b/%b/%h", i, gnt, adr, vld, y, e[9:7], e[6:5], e[4], e[3:0]);
      end
    end
  endtask

`ifdef MS3_ARB_LOCK_EN
  // lock holds owner 0 for 10 cycles despite req[1]; dropping it hands over.
  task automatic test_lock();
    logic [9:0] e;
    lock = 1'b1;
    req  = 3'b011;
    for (int i = 1; i <= 14; i++) begin
      if (i == 11) lock = 1'b0;
      if (i == 13) req = 3'b000;
      step();
      if (i == 1)       e = {3'b001, 2'b00, 1'b0, 4'h0};
      else if (i <= 10) e = {3'b001, 2'b00, 1'b1, 4'h1};
      else if (i == 11) e = {3'b010, 2'b10, 1'b1, 4'h1};
      else if (i == 12) e = {3'b010, 2'b10, 1'b1, 4'h2};
      else if (i == 13) e = {3'b000, 2'b11, 1'b1, 4'h2};
      else              e = {3'b000, 2'b11, 1'b0, 4'h0};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL lock step %0d: gnt/adr/vld/y got %b/%b/%b/%h want %b/%b/%b/%h", i, gnt, adr, vld, y, e[9:7], e[6:5], e[4], e[3:0]);
      end
    end
  endtask
`endif

  initial begin
`ifdef MS3_ARB_LOCK_EN
    lock = 1'b0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_idle_return();
    test_burst_wait();
`ifdef MS3_ARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ms3_rr_arbiter.md
Name: ms3_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the 3:1, 4-bit address-selected multiplexer.
- Shares the multiplexer between three requesters: grants one at a time, drives the select code `adr`, and registers the selected word with a valid flag.
- Instantiates the 3:1 multiplexer internally; sits between requester logic and the downstream consumer of `y`.

Parameters:
- W, 4, data width of x0/x1/x2/y; the multiplexer path is 4 bits, so only W=4 is supported.
- BURST, 4, maximum consecutive cycles one requester holds the grant while others are waiting; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  3  request bits; req[i] belongs to source xi.
- x0  input  W  data of requester 0.
- x1  input  W  data of requester 1.
- x2  input  W  data of requester 2.
- gnt  output  3  registered one-hot grant; all zero when idle.
- adr  output  2  registered select code driven to the multiplexer.
- y  output  W  registered multiplexer output.
- vld  output  1  y holds data of a granted requester.
- lock  input  1  burst-extend request; present only with MS3_ARB_LOCK_EN.

Behaviour:
- Select encoding (fixed by the multiplexer):
  - owner 0 -> adr=2'b00.
  - owner 1 -> adr=2'b10.
  - owner 2 -> adr=2'b01.
  - idle -> adr=2'b11, which selects no input, so the multiplexer output is 0.
- Reset (async, rst_n=0):
  - gnt=3'b000, adr=2'b11, y=0, vld=0.
  - Round-robin pointer ptr=0; burst counter cnt=0; state IDLE.
  - Reset mid-grant aborts the grant immediately, with no completion cycle.
- States: IDLE, BUSY.
- IDLE:
  - If req!=0, choose the first set bit scanning ptr, ptr+1, ptr+2 (mod 3).
  - Next edge: gnt=onehot(owner), adr=code(owner), cnt=1, go to BUSY.
  - If req=0, stay in IDLE with adr=2'b11.
- BUSY, owner o:
  - Release when req[o]=0, or when cnt==BURST and another req bit is set.
  - If cnt==BURST and no other requester is waiting, o keeps the grant and cnt saturates at BURST.
  - On release: ptr=o+1 (mod 3), then arbitrate in the same cycle among the remaining req bits, excluding o.
  - If a winner exists: grant it next edge (back-to-back, no idle gap), cnt=1.
  - If no winner: go to IDLE next edge (gnt=0, adr=2'b11).
  - Otherwise cnt increments.
- Simultaneous events:
  - req[o] drops on the same cycle cnt reaches BURST: a single release, same result as above.
  - New requests arriving mid-burst wait; they never pre-empt the owner before BURST.
- Data path:
  - y <= mux(x0,x1,x2,adr) on every edge, using the current registered adr.
  - vld <= (gnt!=0).
  - Latency: req rising at edge n -> gnt/adr at edge n+1 -> y/vld at edge n+2.
  - vld=0 implies y=0.
- Invariants:
  - gnt is always one-hot or zero.
  - adr is always consistent with gnt.
  - adr never takes a code other than the four listed.
- cnt width: 4 bits, compared as unsigned against BURST.

Optional Feature:
- Macro: MS3_ARB_LOCK_EN.
- Defined:
  - Adds the `lock` input.
  - While lock=1 and req[o]=1, the BURST limit is ignored and the owner keeps the grant; cnt saturates at BURST.
  - Dropping lock with cnt>=BURST and other requests pending releases on the next evaluation cycle.
  - lock is ignored in IDLE.
- Undefined:
  - No `lock` port.
  - BURST is always enforced.

Test Plan:
- Reset: assert rst_n=0 mid-BUSY with gnt=3'b010 -> gnt=0, adr=2'b11, y=0, vld=0 without waiting for a clock edge; after release, req=3'b001 -> gnt=3'b001 one edge later.
- Single requester: req=3'b100, x2=4'hA -> gnt=3'b100 and adr=2'b01 at +1 edge; y=4'hA and vld=1 at +2 edge; grant held indefinitely while only req[2] is set.
- Round robin (BURST=4): req=3'b111 held, x0=1, x1=2, x2=3 -> owners 0,1,2,0 each for exactly 4 cycles, back-to-back; y sequence 1,1,1,1,2,2,2,2,3...
- Early release: owner 1 drops req[1] after 2 cycles while req=3'b101 -> next owner is 2 (ptr=2), not 0; adr 2'b10 -> 2'b01 with no idle cycle.
- Idle return: sole owner 0 drops req -> gnt=0, adr=2'b11 next edge; y=0 and vld=0 one edge later.
- With MS3_ARB_LOCK_EN: lock=1, owner 0, req=3'b011 -> owner 0 holds for 10 cycles; lock falls -> gnt=3'b010 on the following edge.
